// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART TX among N_REQ byte producers
module uart_tx_scheduler #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int GAP_TICKS = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_tick,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic                      o_tx_start,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_done,
    output logic                      o_busy,
    output logic [$clog2(N_REQ)-1:0]  o_grant_id
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    logic [1:0]        state;
    logic [ID_W-1:0]   last_grant;
    logic [GAP_W-1:0]  gap_cnt;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   ptr;
    logic [DATA_W-1:0] req_bytes [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_bytes[k] = i_req_data[k*DATA_W +: DATA_W];
    end

    // Search starts one past the last grant so a held requester waits its turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        ptr       = last_grant;
        for (int i = 0; i < N_REQ; i++) begin
            ptr = (ptr == ID_W'(N_REQ - 1)) ? '0 : ptr + ID_W'(1);
            if (!win_found && i_req_valid[ptr]) begin
                win_found = 1'b1;
                win_idx   = ptr;
            end
        end
    end

    assign o_req_ready = (i_reset_n && state == ST_IDLE && win_found)
                       ? (N_REQ'(1) << win_idx) : '0;
    assign o_tx_start  = (state == ST_START);
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            gap_cnt    <= '0;
            o_tx_data  <= '0;
            o_grant_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        o_tx_data  <= req_bytes[win_idx];
                        o_grant_id <= win_idx;
                        last_grant <= win_idx;
                        state      <= ST_START;
                    end
                end
                ST_START: state <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (i_tx_done) begin
                        gap_cnt <= '0;
                        state   <= (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (i_tick) begin
                        // Counter stops at GAP_TICKS on exit, so it never wraps.
                        gap_cnt <= gap_cnt + GAP_W'(1);
                        if (gap_cnt == GAP_LAST)
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - table-driven scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        i_tick = 1'b0;
    logic [3:0]  i_req_valid = '0;
    logic [31:0] i_req_data = '0;
    logic [3:0]  o_req_ready;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_done = 1'b0;
    logic        o_busy;
    logic [1:0]  o_grant_id;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          rst;
        logic [3:0]  valid;
        logic [31:0] data;
        int          exp_id;
        bit          spur;
        bit          ghold;
    } vec_t;
    vec_t vecs[13];

    uart_tx_scheduler #(.N_REQ(4), .DATA_W(8), .GAP_TICKS(16)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_tick      (i_tick),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_done   (i_tx_done),
        .o_busy      (o_busy),
        .o_grant_id  (o_grant_id)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_reset_n && o_tx_start) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_start", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_tx_data", o_tx_data, e.data);
                chk("sb_grant_id", o_grant_id, e.id);
            end
        end
    end

    task automatic do_reset();
        i_req_valid = 4'hF;
        i_reset_n = 1'b0;
        @(negedge i_clk);
        chk("rst_ready_forced", o_req_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", o_tx_start, 0);
        chk("rst_data", o_tx_data, 0);
        chk("rst_grant", o_grant_id, 0);
        i_req_valid = '0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic do_txn(input logic [3:0] v, input logic [31:0] d, input int exp_id,
                          input bit spur, input bit ghold);
        logic [7:0] exp_byte;
        exp_byte = d[exp_id*8 +: 8];
        i_req_valid = v;
        i_req_data  = d;
        #1;
        chk("ready_onehot", o_req_ready, 1 << exp_id);
        chk("busy_idle", o_busy, 0);
        sb.push_back('{exp_id[1:0], exp_byte});
        @(negedge i_clk);
        i_req_valid = '0;
        chk("tx_start", o_tx_start, 1);
        chk("busy_start", o_busy, 1);
        chk("ready_low_busy", o_req_ready, 0);
        if (spur) i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        chk("start_one_cycle", o_tx_start, 0);
        if (spur) begin
            i_tick = 1'b1;
            repeat (16) @(negedge i_clk);
            i_tick = 1'b0;
            chk("spurious_done_ignored", o_busy, 1);
        end
        repeat (4) @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (ghold && t == 8) begin
                repeat (5) @(negedge i_clk);
                i_tx_done = 1'b1;
                @(negedge i_clk);
                i_tx_done = 1'b0;
                repeat (4) @(negedge i_clk);
                chk("gap_no_tick_hold", o_busy, 1);
            end
            if (t == 15) chk("busy_before_last_tick", o_busy, 1);
            i_tick = 1'b1;
            @(negedge i_clk);
            i_tick = 1'b0;
        end
        chk("busy_after_gap", o_busy, 0);
        chk("tx_data_stable", o_tx_data, exp_byte);
        chk("grant_id_stable", o_grant_id, exp_id);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'b0001, 32'h1122_33A5, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 32'h4D3C_2B1A, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 32'h5E4D_3C2B, 1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 32'h6F5E_4D3C, 2, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 4'b1111, 32'h706F_5E4D, 3, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 32'h8170_6F5E, 0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 32'h9281_706F, 1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'b0100, 32'hA392_8170, 2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0011, 32'hB4A3_9281, 0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'b0011, 32'hC5B4_A392, 1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b1010, 32'hD6C5_B4A3, 3, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b1010, 32'hE7D6_C5B4, 1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b1000, 32'hF8E7_D6C5, 3, 1'b0, 1'b0};

        #2 i_reset_n = 1'b0;
        @(negedge i_clk);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst) do_reset();
            do_txn(vecs[i].valid, vecs[i].data, vecs[i].exp_id, vecs[i].spur, vecs[i].ghold);
        end

        // Reset during WAIT_DONE, then priority returns to requester 0.
        i_req_valid = 4'b0100;
        i_req_data  = 32'h0F1E_2D3C;
        #1;
        chk("mid_ready", o_req_ready, 4'b0100);
        sb.push_back('{2'd2, 8'h1E});
        @(negedge i_clk);
        i_req_valid = '0;
        chk("mid_start", o_tx_start, 1);
        repeat (2) @(negedge i_clk);
        i_req_valid = 4'hF;
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_data", o_tx_data, 0);
        chk("mid_rst_grant", o_grant_id, 0);
        chk("mid_rst_start", o_tx_start, 0);
        chk("mid_rst_ready", o_req_ready, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        #1;
        chk("post_rst_priority", o_req_ready, 4'b0001);
        i_req_valid = '0;
        @(negedge i_clk);
        chk("post_rst_no_start", o_tx_start, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter among `N_REQ` requesters. It accepts one byte at a time through a valid/ready handshake and launches it on the transmitter with a single-cycle start pulse. It then waits for the transmitter's done strobe and enforces a programmable inter-frame gap, counted in oversampling ticks from the baud-rate generator. It sits between the baud-rate generator / UART TX pair and the on-chip byte producers.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2.
- `DATA_W`, 8: byte width.
- `GAP_TICKS`, 16: idle gap after each frame, in `i_tick` pulses. 16 equals one bit time at 16x oversampling. 0 disables the gap.

Ports:
- `i_clk`, in, 1: system clock; all logic on the rising edge.
- `i_reset_n`, in, 1: asynchronous, active-low reset.
- `i_tick`, in, 1: baud oversampling tick from the baud-rate generator; one-cycle pulse.
- `i_req_valid`, in, `N_REQ`: requester k has a byte pending.
- `i_req_data`, in, `N_REQ*DATA_W`: byte of requester k on `[k*DATA_W +: DATA_W]`.
- `o_req_ready`, out, `N_REQ`: one-hot accept; a transfer occurs on the edge where `valid[k] & ready[k]`.
- `o_tx_start`, out, 1: one-cycle launch pulse to the UART TX.
- `o_tx_data`, out, `DATA_W`: byte to transmit; stable from the accept edge until the next accept.
- `i_tx_done`, in, 1: one-cycle strobe from the UART TX at end of stop bit.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_grant_id`, out, `$clog2(N_REQ)`: index of the last accepted requester.

## Operation
- FSM states: IDLE, START, WAIT_DONE, GAP. Reset state is IDLE.
- **IDLE:**
  - If any `i_req_valid` bit is set, select winner k by round-robin, searching from `(last_grant+1) mod N_REQ` upward with wrap.
  - `o_req_ready[k]` is combinational: high only in IDLE, only for the winner.
  - On the accept edge: `o_tx_data <= data[k]`, `o_grant_id <= k`, `last_grant <= k`, go to START.
  - With no valid bits set, stay in IDLE with `o_req_ready` = 0.
- **START:** `o_tx_start` = 1 for exactly this one cycle; unconditionally go to WAIT_DONE.
- **WAIT_DONE:**
  - Wait for `i_tx_done`.
  - On `i_tx_done`: clear the gap counter; go to GAP, or directly to IDLE if `GAP_TICKS == 0`.
- **GAP:**
  - Increment the gap counter on each `i_tick`.
  - On the `i_tick` where counter == `GAP_TICKS-1`, go to IDLE.
  - Counter width is `$clog2(GAP_TICKS+1)`; it never wraps.
- `last_grant` resets to `N_REQ-1`, so requester 0 has first priority after reset.
- `i_tx_done` is ignored outside WAIT_DONE, including a done strobe in the START cycle. `i_tick` is ignored outside GAP.
- A requester that drops valid before being accepted loses nothing; it is simply skipped.
- A requester holding valid continuously is served again only after every other active requester has had one turn.

## Timing
- Reset values: `o_tx_start` 0, `o_tx_data` 0, `o_grant_id` 0, `o_busy` 0, `o_req_ready` 0. `last_grant` = `N_REQ-1`, gap counter 0.
- While `i_reset_n` is low, `o_req_ready` is forced to 0.
- Accept latency: ready is asserted in the same cycle that valid is seen in IDLE.
- `o_tx_start` is high the cycle after the accept edge.
- `o_busy` rises the cycle after the accept edge. It falls the cycle after the GAP exit edge, or after the WAIT_DONE exit edge when `GAP_TICKS == 0`.
- Back-to-back accepts: the next accept occurs no earlier than the first IDLE cycle after the gap. The minimum accept-to-accept spacing is 3 cycles plus the transmitter time plus the gap.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. No start pulse is issued and the pending byte is dropped.

## Test plan
- **Single request:** reset, then `valid` = 0001 with data `8'hA5`.
  - Required: `ready[0]` high the same cycle, `o_tx_start` pulse the next cycle, `o_tx_data` = A5, `o_grant_id` = 0.
  - Then drive `i_tx_done`; exactly 16 `i_tick` pulses later `o_busy` = 0.
- **Round-robin fairness:** all four valid held high, `i_tx_done` returned 5 cycles after each start, `GAP_TICKS` = 2.
  - Required: grant order 0, 1, 2, 3, 0, 1, with exactly one ready bit per accept.
- **Skip and wrap:** `last_grant` = 2 and `valid` = 0011.
  - Required: requester 0 granted next, then requester 1.
- **Gap accounting:** during GAP, insert 10 cycles without `i_tick`, plus one `i_tx_done` strobe.
  - Required: neither event advances the gap counter. IDLE is reached only after the `GAP_TICKS`-th tick.
- **Spurious done:** `i_tx_done` asserted in the START cycle.
  - Required: it is ignored and the FSM stays in WAIT_DONE until the next done strobe.
- **Reset mid-frame:** drop `i_reset_n` during WAIT_DONE.
  - Required: all outputs return to reset values asynchronously, and after release requester 0 has priority.
